// File: rtl/uart_block_receiver.sv
// UART 8N1 receiver that gathers NUM_BYTES serial bytes into one block and
// hands it to the AES input stage over a valid/ready handshake.
module uart_block_receiver #(
   parameter int unsigned CLOCK_FREQ = 50000000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned NUM_BYTES  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     rx,
   output logic [8*NUM_BYTES-1:0]   block_data,
   output logic                     block_valid,
   input  logic                     block_ready,
   output logic                     busy,
   output logic                     frame_err,
   output logic                     overrun
);

   localparam int unsigned BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned BLOCK_W    = 8 * NUM_BYTES;
   localparam logic [15:0] HALF_LAST  = 16'(BIT_PERIOD / 2 - 1);
   localparam logic [15:0] FULL_LAST  = 16'(BIT_PERIOD - 1);
   localparam logic [3:0]  LAST_SLOT  = 4'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic                 rx_meta_r, rx_sync_r;
   logic [15:0]          baud_cnt_r, baud_cnt_s;
   logic [2:0]           bit_idx_r, bit_idx_s;
   logic [3:0]           byte_cnt_r, byte_cnt_s;
   logic [7:0]           shift_r, shift_s;
   logic [BLOCK_W-1:0]   block_buf_r, block_buf_s;
   logic [BLOCK_W-1:0]   filled_s;
   logic [BLOCK_W-1:0]   block_data_r, block_data_s;
   logic                 block_valid_r, block_valid_s;
   logic                 busy_r, busy_s;
   logic                 frame_err_r, frame_err_s;
   logic                 overrun_r, overrun_s;

   function automatic logic [BLOCK_W-1:0] insert_byte(
      input logic [BLOCK_W-1:0] blk,
      input logic [3:0]         slot,
      input logic [7:0]         b
   );
      logic [BLOCK_W-1:0] r;
      r = blk;
      r[8*slot +: 8] = b;
      return r;
   endfunction

   // two-flop synchronizer for the asynchronous rx pin; idles high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // next-state, framing, block assembly and handshake logic
   always_comb begin
      state_s       = state_r;
      baud_cnt_s    = baud_cnt_r;
      bit_idx_s     = bit_idx_r;
      byte_cnt_s    = byte_cnt_r;
      shift_s       = shift_r;
      block_buf_s   = block_buf_r;
      block_data_s  = block_data_r;
      block_valid_s = block_valid_r && !block_ready;
      frame_err_s   = 1'b0;
      overrun_s     = 1'b0;
      filled_s      = insert_byte(block_buf_r, byte_cnt_r, shift_r);

      case (state_r)
         ST_IDLE: begin
            if (!rx_sync_r) begin
               state_s    = ST_START;
               baud_cnt_s = 16'd0;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_START: begin
            // a start bit that is high again at its midpoint was a glitch
            if (baud_cnt_r == HALF_LAST) begin
               baud_cnt_s = 16'd0;
               if (rx_sync_r) begin
                  state_s   = ST_IDLE;
               end else begin
                  state_s   = ST_DATA;
                  bit_idx_s = 3'd0;
               end
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_cnt_r == FULL_LAST) begin
               baud_cnt_s = 16'd0;
               shift_s    = {rx_sync_r, shift_r[7:1]};
               if (bit_idx_r == 3'd7) begin
                  state_s   = ST_STOP;
               end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
               end
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         ST_STOP: begin
            if (baud_cnt_r == FULL_LAST) begin
               state_s    = ST_IDLE;
               baud_cnt_s = 16'd0;
               if (rx_sync_r) begin
                  block_buf_s = filled_s;
                  if (byte_cnt_r == LAST_SLOT) begin
                     byte_cnt_s = 4'd0;
                     // a full output that is not being drained loses the new block
                     if (!block_valid_r || block_ready) begin
                        block_data_s  = filled_s;
                        block_valid_s = 1'b1;
                     end else begin
                        overrun_s     = 1'b1;
                     end
                  end else begin
                     byte_cnt_s = byte_cnt_r + 4'd1;
                  end
               end else begin
                  // bad stop bit: drop the partial block to resync on a block boundary
                  frame_err_s = 1'b1;
                  byte_cnt_s  = 4'd0;
               end
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            baud_cnt_s = 16'd0;
         end
      endcase

      busy_s = (state_s != ST_IDLE) || (byte_cnt_s != 4'd0);
   end

   // state and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         baud_cnt_r    <= 16'd0;
         bit_idx_r     <= 3'd0;
         byte_cnt_r    <= 4'd0;
         shift_r       <= 8'd0;
         block_buf_r   <= '0;
         block_data_r  <= '0;
         block_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         frame_err_r   <= 1'b0;
         overrun_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         baud_cnt_r    <= baud_cnt_s;
         bit_idx_r     <= bit_idx_s;
         byte_cnt_r    <= byte_cnt_s;
         shift_r       <= shift_s;
         block_buf_r   <= block_buf_s;
         block_data_r  <= block_data_s;
         block_valid_r <= block_valid_s;
         busy_r        <= busy_s;
         frame_err_r   <= frame_err_s;
         overrun_r     <= overrun_s;
      end
   end

   assign block_data  = block_data_r;
   assign block_valid = block_valid_r;
   assign busy        = busy_r;
   assign frame_err   = frame_err_r;
   assign overrun     = overrun_r;

endmodule

// File: tb/tb_uart_block_receiver.sv
// Scoreboard bench for uart_block_receiver with BIT_PERIOD = 16 clocks.
module tb_uart_block_receiver;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         rx;
   logic [127:0] block_data;
   logic         block_valid;
   logic         block_ready;
   logic         busy;
   logic         frame_err;
   logic         overrun;

   int n_vec = 0;
   int n_err = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int vld_cycles = 0;
   logic [127:0] exp_q[$];

   uart_block_receiver #(
      .CLOCK_FREQ (16),
      .BAUD_RATE  (1),
      .NUM_BYTES  (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx          (rx),
      .block_data  (block_data),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .busy        (busy),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   // pulse counters and handshake scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      logic [127:0] exp_blk;
      if (frame_err)   ferr_cnt++;
      if (overrun)     ovr_cnt++;
      if (block_valid) vld_cycles++;
      if (block_valid && block_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL handshake_unexpected: got block %h, required no block", block_data);
         end else begin
            exp_blk = exp_q.pop_front();
            if (block_data !== exp_blk) begin
               n_err++;
               $display("FAIL handshake_data: got %h, required %h", block_data, exp_blk);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [127:0] make_block(input logic [7:0] base);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
      return r;
   endfunction

   // one 8N1 frame; optional ready pulse lands on the cycle before the stop midpoint
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit ready_pulse);
      rx = 1'b0;
      repeat (16) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (16) tick();
      end
      rx = stop_bit;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (ready_pulse && i == 10) block_ready = 1'b1;
         if (ready_pulse && i == 11) block_ready = 1'b0;
      end
      rx = 1'b1;
   endtask

   task automatic send_block(input logic [7:0] base, input bit push);
      if (push) exp_q.push_back(make_block(base));
      for (int k = 0; k < 16; k++) send_byte(base + 8'(k), 1'b1, 1'b0);
   endtask

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      block_ready = 1'b0;
      repeat (3) tick();
      chk("reset_valid", {127'd0, block_valid}, 128'd0);
      chk("reset_data", block_data, 128'd0);
      chk("reset_busy", {127'd0, busy}, 128'd0);
      chk("reset_ferr", {127'd0, frame_err}, 128'd0);
      chk("reset_ovr", {127'd0, overrun}, 128'd0);
      reset_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_single_block();
      int v0;
      int f0;
      v0 = vld_cycles;
      f0 = ferr_cnt;
      block_ready = 1'b1;
      send_block(8'h00, 1'b1);
      repeat (4) tick();
      chk("single_valid_cycles", 128'(vld_cycles - v0), 128'd1);
      chk("single_queue_empty", 128'(exp_q.size()), 128'd0);
      chk("single_busy", {127'd0, busy}, 128'd0);
      chk("single_no_ferr", 128'(ferr_cnt - f0), 128'd0);
   endtask

   task automatic test_overrun();
      int o0;
      o0 = ovr_cnt;
      block_ready = 1'b0;
      send_block(8'h20, 1'b1);
      send_block(8'h40, 1'b0);
      chk("ovr_pulses", 128'(ovr_cnt - o0), 128'd1);
      chk("ovr_valid_held", {127'd0, block_valid}, 128'd1);
      chk("ovr_data_held", block_data, make_block(8'h20));
      block_ready = 1'b1;
      tick();
      block_ready = 1'b0;
      tick();
      chk("ovr_valid_clear", {127'd0, block_valid}, 128'd0);
      chk("ovr_queue_empty", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic test_glitch();
      int f0;
      int v0;
      f0 = ferr_cnt;
      v0 = vld_cycles;
      rx = 1'b0;
      repeat (4) tick();
      rx = 1'b1;
      repeat (2) tick();
      chk("glitch_busy_start", {127'd0, busy}, 128'd1);
      repeat (20) tick();
      chk("glitch_busy_drop", {127'd0, busy}, 128'd0);
      chk("glitch_no_ferr", 128'(ferr_cnt - f0), 128'd0);
      chk("glitch_no_valid", 128'(vld_cycles - v0), 128'd0);
   endtask

   task automatic test_frame_error();
      int f0;
      int v0;
      f0 = ferr_cnt;
      v0 = vld_cycles;
      block_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_byte(8'(k), 1'b1, 1'b0);
      send_byte(8'h03, 1'b0, 1'b0);
      repeat (40) tick();
      chk("ferr_pulses", 128'(ferr_cnt - f0), 128'd1);
      chk("ferr_bytecnt_cleared", {127'd0, busy}, 128'd0);
      chk("ferr_no_valid", 128'(vld_cycles - v0), 128'd0);
      send_block(8'h60, 1'b1);
      repeat (4) tick();
      chk("ferr_recover_valid", 128'(vld_cycles - v0), 128'd1);
      chk("ferr_queue_empty", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic test_reset_midframe();
      block_ready = 1'b0;
      send_block(8'h80, 1'b0);
      for (int k = 0; k < 10; k++) send_byte(8'h90 + 8'(k), 1'b1, 1'b0);
      rx = 1'b0;
      repeat (16) tick();
      rx = 1'b1;
      repeat (40) tick();
      chk("midrst_busy_before", {127'd0, busy}, 128'd1);
      chk("midrst_valid_before", {127'd0, block_valid}, 128'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", {127'd0, block_valid}, 128'd0);
      chk("midrst_data", block_data, 128'd0);
      chk("midrst_busy", {127'd0, busy}, 128'd0);
      chk("midrst_flags", {126'd0, frame_err, overrun}, 128'd0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      block_ready = 1'b1;
      send_block(8'hA0, 1'b1);
      repeat (4) tick();
      chk("midrst_queue_empty", 128'(exp_q.size()), 128'd0);
      chk("midrst_valid_after", {127'd0, block_valid}, 128'd0);
   endtask

   task automatic test_back_to_back();
      int o0;
      o0 = ovr_cnt;
      block_ready = 1'b0;
      send_block(8'hB0, 1'b1);
      exp_q.push_back(make_block(8'hC0));
      for (int k = 0; k < 15; k++) send_byte(8'hC0 + 8'(k), 1'b1, 1'b0);
      send_byte(8'hCF, 1'b1, 1'b1);
      chk("b2b_valid_stays", {127'd0, block_valid}, 128'd1);
      chk("b2b_new_data", block_data, make_block(8'hC0));
      chk("b2b_no_overrun", 128'(ovr_cnt - o0), 128'd0);
      block_ready = 1'b1;
      repeat (3) tick();
      block_ready = 1'b0;
      chk("b2b_valid_clear", {127'd0, block_valid}, 128'd0);
      chk("b2b_queue_empty", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_overrun();
      test_glitch();
      test_frame_error();
      test_reset_midframe();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
